// File: rtl/sub_d_collect_d.sv
// sub_d_collect_d: samples sub_d's outputs every clock, queues each change of the
// 4-bit result word in a small FIFO and drains it through a valid/ready port.
module sub_d_collect_d #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk_d,
    input  logic                   rst_n_d,
    input  logic                   en_d,
    input  logic                   testo1_d,
    input  logic [1:0]             testo2_d,
    input  logic                   testo1_sub_d,
    output logic                   out_valid_d,
    input  logic                   out_ready_d,
    output logic [3:0]             out_data_d,
    output logic [$clog2(DEPTH):0] fifo_level_d,
    output logic                   overflow_d,
    input  logic                   clr_ovf_d,
    output logic [CNT_W-1:0]       evt_cnt_d
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      ONE_LVL  = (AW+1)'(1);
    localparam logic [AW-1:0]    ONE_PTR  = AW'(1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [3:0]    smp;
    logic          smp_en;
    logic [3:0]    last;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          evt;
    logic          pop;
    logic          push;
    logic          full;
    logic          drop;

    // Stage 1: register the raw inputs and the enable that qualifies them.
    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            smp    <= '0;
            smp_en <= 1'b0;
        end else begin
            smp    <= {testo1_sub_d, testo2_d, testo1_d};
            smp_en <= en_d;
        end
    end

    always_comb begin
        evt  = smp_en && (smp != last);
        full = (level == FULL_LVL);
        pop  = out_valid_d && out_ready_d;
        push = evt && (!full || pop);
        drop = evt && full && !pop;
    end

    // Stage 2: last only moves on an event, so it holds across en_d=0 stretches.
    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            last <= '0;
        end else if (evt) begin
            last <= smp;
        end
    end

    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= smp;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            overflow_d <= 1'b0;
        end else if (drop) begin
            overflow_d <= 1'b1;
        end else if (clr_ovf_d) begin
            overflow_d <= 1'b0;
        end
    end

    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            evt_cnt_d <= '0;
        end else if (evt && (evt_cnt_d != '1)) begin
            evt_cnt_d <= evt_cnt_d + ONE_CNT;
        end
    end

    always_comb begin
        out_valid_d  = (level != '0);
        out_data_d   = out_valid_d ? mem[rd_ptr] : '0;
        fifo_level_d = level;
    end

endmodule

// File: tb/tb_sub_d_collect_d.sv
// Bench for sub_d_collect_d: table-driven start-up vectors, directed corner sequences
// and a randomized phase against a queue-based reference model.
module tb_sub_d_collect_d;

    localparam int DEPTH = 4;

    logic       clk_d = 1'b0;
    logic       rst_n_d;
    logic       en_d;
    logic       testo1_d;
    logic [1:0] testo2_d;
    logic       testo1_sub_d;
    logic       out_ready_d;
    logic       clr_ovf_d;

    logic       out_valid_d, out_valid2;
    logic [3:0] out_data_d, out_data2;
    logic [2:0] fifo_level_d, fifo_level2;
    logic       overflow_d, overflow2;
    logic [7:0] evt_cnt_d;
    logic [1:0] evt_cnt2;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int   m_q[$];
    logic [3:0] m_smp;
    logic       m_smp_en;
    logic [3:0] m_last;
    logic       m_ovf;
    int         m_cnt;

    always #5 clk_d = ~clk_d;

    sub_d_collect_d #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk_d(clk_d), .rst_n_d(rst_n_d), .en_d(en_d),
        .testo1_d(testo1_d), .testo2_d(testo2_d), .testo1_sub_d(testo1_sub_d),
        .out_valid_d(out_valid_d), .out_ready_d(out_ready_d), .out_data_d(out_data_d),
        .fifo_level_d(fifo_level_d), .overflow_d(overflow_d), .clr_ovf_d(clr_ovf_d),
        .evt_cnt_d(evt_cnt_d)
    );

    sub_d_collect_d #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk_d(clk_d), .rst_n_d(rst_n_d), .en_d(en_d),
        .testo1_d(testo1_d), .testo2_d(testo2_d), .testo1_sub_d(testo1_sub_d),
        .out_valid_d(out_valid2), .out_ready_d(out_ready_d), .out_data_d(out_data2),
        .fifo_level_d(fifo_level2), .overflow_d(overflow2), .clr_ovf_d(clr_ovf_d),
        .evt_cnt_d(evt_cnt2)
    );

    typedef struct packed {
        logic       en;
        logic [3:0] word;
        logic       ready;
        logic       exp_valid;
        logic [3:0] exp_data;
        logic [3:0] exp_level;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [3:0] w);
        testo1_sub_d = w[3];
        testo2_d     = w[2:1];
        testo1_d     = w[0];
    endtask

    task automatic model_reset();
        m_q.delete();
        m_smp    = '0;
        m_smp_en = 1'b0;
        m_last   = '0;
        m_ovf    = 1'b0;
        m_cnt    = 0;
    endtask

    // Applies the rules for one clock edge using the inputs present before the edge.
    task automatic model_step();
        bit pop, evt, push;
        pop  = (m_q.size() != 0) && out_ready_d;
        evt  = m_smp_en && (m_smp != m_last);
        push = 1'b0;
        if (evt) begin
            m_last = m_smp;
            m_cnt++;
            push = (m_q.size() < DEPTH) || pop;
        end
        if (evt && !push) m_ovf = 1'b1;
        else if (clr_ovf_d) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(int'(m_smp));
        m_smp    = {testo1_sub_d, testo2_d, testo1_d};
        m_smp_en = en_d;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_d);
        #1;
    endtask

    task automatic check_model(input string tag);
        int lvl, head;
        lvl  = m_q.size();
        head = (lvl != 0) ? m_q[0] : 0;
        chk({tag, ".valid"}, 32'(out_valid_d), 32'(lvl != 0));
        chk({tag, ".data"},  32'(out_data_d),  32'(head));
        chk({tag, ".level"}, 32'(fifo_level_d), 32'(lvl));
        chk({tag, ".ovf"},   32'(overflow_d),  32'(m_ovf));
        chk({tag, ".cnt"},   32'(evt_cnt_d),   32'((m_cnt > 255) ? 255 : m_cnt));
        chk({tag, ".cnt2"},  32'(evt_cnt2),    32'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"},  32'(out_valid_d),  0);
        chk({tag, ".data"},   32'(out_data_d),   0);
        chk({tag, ".level"},  32'(fifo_level_d), 0);
        chk({tag, ".ovf"},    32'(overflow_d),   0);
        chk({tag, ".cnt"},    32'(evt_cnt_d),    0);
        chk({tag, ".valid2"}, 32'(out_valid2),   0);
        chk({tag, ".data2"},  32'(out_data2),    0);
        chk({tag, ".cnt2"},   32'(evt_cnt2),     0);
    endtask

    logic [3:0] w3[5];
    logic [3:0] w4[5];
    logic [3:0] w5[5];

    initial begin
        rst_n_d = 1'b0;
        en_d = 1'b0; out_ready_d = 1'b0; clr_ovf_d = 1'b0;
        set_word(4'b0000);
        model_reset();

        // First event two edges after the word appears, then ten held cycles with ready.
        vecs[0] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'd0, 8'd0};
        vecs[1] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'd1, 8'd1};
        for (int i = 2; i < 12; i++) begin
            vecs[i] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'd0, 8'd1};
        end
        w3 = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110};
        w4 = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
        w5 = '{4'b1101, 4'b1110, 4'b1111, 4'b0000, 4'b0111};

        #8;
        check_zero("reset");
        #4;
        rst_n_d = 1'b1;

        for (int i = 0; i < 12; i++) begin
            en_d = vecs[i].en;
            set_word(vecs[i].word);
            out_ready_d = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d.valid", i), 32'(out_valid_d), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.data", i),  32'(out_data_d),  32'(vecs[i].exp_data));
            chk($sformatf("vec%0d.level", i), 32'(fifo_level_d), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d.cnt", i),   32'(evt_cnt_d),   32'(vecs[i].exp_cnt));
        end

        // Five distinct words with no consumer: four stored, one dropped.
        out_ready_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_word(w3[i]);
            tick();
        end
        tick();
        chk("fill.level", 32'(fifo_level_d), 4);
        chk("fill.ovf",   32'(overflow_d),   1);
        chk("fill.cnt",   32'(evt_cnt_d),    6);
        chk("fill.cnt2",  32'(evt_cnt2),     3);
        check_model("fill");
        out_ready_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.data", i), 32'(out_data_d), 32'(w3[i]));
            tick();
        end
        chk("drain.level", 32'(fifo_level_d), 0);
        chk("drain.ovf_kept", 32'(overflow_d), 1);
        clr_ovf_d = 1'b1;
        tick();
        clr_ovf_d = 1'b0;
        chk("clr.ovf", 32'(overflow_d), 0);

        // Full FIFO with a push and a pop on the same edge.
        out_ready_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_word(w4[i]);
            tick();
        end
        chk("full.level", 32'(fifo_level_d), 4);
        out_ready_d = 1'b1;
        tick();
        chk("pushpop.level", 32'(fifo_level_d), 4);
        chk("pushpop.ovf",   32'(overflow_d),   0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("pushpop%0d.data", i), 32'(out_data_d), 32'(w4[i]));
            tick();
        end
        check_model("pushpop");

        // Drop and clear on the same edge: the drop wins.
        out_ready_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_word(w5[i]);
            tick();
        end
        clr_ovf_d = 1'b1;
        tick();
        chk("setclr.ovf", 32'(overflow_d), 1);
        tick();
        clr_ovf_d = 1'b0;
        chk("clronly.ovf", 32'(overflow_d), 0);
        chk("sat.cnt2", 32'(evt_cnt2), 3);
        check_model("sat");

        // Asynchronous reset in the middle of a drain.
        out_ready_d = 1'b1;
        tick();
        chk("middrain.level", 32'(fifo_level_d), 3);
        #2;
        rst_n_d = 1'b0;
        #1;
        check_zero("asyncrst");
        @(negedge clk_d);
        rst_n_d = 1'b1;
        model_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            en_d        = ($urandom_range(0, 7) != 0);
            set_word(4'($urandom_range(0, 5)));
            out_ready_d = ($urandom_range(0, 2) == 0);
            clr_ovf_d   = ($urandom_range(0, 15) == 0);
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
